// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package pc_fetch_unit_pkg;

  localparam int          DEFAULT_ADDR_W   = 64;
  localparam int          DEFAULT_INSTR_W  = 32;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;
  localparam int          DEFAULT_PC_STEP  = 4;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  function automatic logic word_misaligned(input logic [1:0] low_bits);
    return |low_bits;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid register that parks a fetched {pc, instr} while IF/ID is stalled.
module fetch_hold_buf #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [ADDR_W-1:0]  load_pc,
  input  logic [INSTR_W-1:0] load_instr,
  output logic               valid,
  output logic [ADDR_W-1:0]  held_pc,
  output logic [INSTR_W-1:0] held_instr
);

  // Clear wins over load so a redirect always empties the entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid      <= 1'b0;
      held_pc    <= '0;
      held_instr <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid      <= 1'b1;
      held_pc    <= load_pc;
      held_instr <= load_instr;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding fetch FSM and IF/ID register.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter int                INSTR_W  = DEFAULT_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int                PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ifid_valid,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic               misalign_err
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, pc_next;
  logic               drop_q, drop_d;
  logic               misalign_q, misalign_d;
  logic               ifid_valid_q, ifid_valid_d, ifid_we;
  logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic               hold_load, hold_clear, hold_valid;
  logic [ADDR_W-1:0]  held_pc;
  logic [INSTR_W-1:0] held_instr;

  assign pc_next      = pc_q + ADDR_W'(PC_STEP);
  assign imem_req     = (state_q == REQ) && !reset;
  assign imem_addr    = pc_q;
  assign ifid_valid   = ifid_valid_q;
  assign ifid_pc      = ifid_pc_q;
  assign ifid_instr   = ifid_instr_q;
  assign misalign_err = misalign_q;

  fetch_hold_buf #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_hold_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (hold_load),
    .clear     (hold_clear),
    .load_pc   (pc_q),
    .load_instr(imem_rdata),
    .valid     (hold_valid),
    .held_pc   (held_pc),
    .held_instr(held_instr)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    misalign_d   = 1'b0;
    ifid_we      = 1'b0;
    ifid_valid_d = 1'b0;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    hold_load    = 1'b0;
    hold_clear   = 1'b0;

    if (branch_taken) begin
      // Redirect beats stall and any response; an in-flight fetch is marked for discard.
      pc_d       = {branch_target[ADDR_W-1:2], 2'b00};
      misalign_d = word_misaligned(branch_target[1:0]);
      ifid_we    = 1'b1;
      case (state_q)
        REQ: begin
          if (imem_ready) begin
            state_d = WAIT;
            drop_d  = 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_d = REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d = 1'b1;
          end
        end
        HOLD: begin
          hold_clear = 1'b1;
          state_d    = REQ;
        end
        default: state_d = REQ;
      endcase
    end else begin
      // Any unstalled cycle that loads nothing inserts a bubble.
      ifid_we = !stall;
      case (state_q)
        REQ: begin
          if (imem_ready) state_d = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = REQ;
            end else if (!stall) begin
              ifid_valid_d = 1'b1;
              ifid_pc_d    = pc_q;
              ifid_instr_d = imem_rdata;
              pc_d         = pc_next;
              state_d      = REQ;
            end else begin
              hold_load = 1'b1;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_valid_d = hold_valid;
            ifid_pc_d    = held_pc;
            ifid_instr_d = held_instr;
            pc_d         = pc_next;
            hold_clear   = 1'b1;
            state_d      = REQ;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      misalign_q   <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      misalign_q <= misalign_d;
      if (ifid_we) begin
        ifid_valid_q <= ifid_valid_d;
        ifid_pc_q    <= ifid_pc_d;
        ifid_instr_q <= ifid_instr_d;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomised bench for pc_fetch_unit against a transaction-level fetch model and memory.
module tb_pc_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h1000;
  localparam int          CYCLES = 4000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        misalign_err;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Model: next fetch address, whether a fetch is in flight (and doomed),
  // whether a stalled instruction is parked, and the expected IF/ID contents.
  logic [63:0] m_pc;
  logic        m_busy, m_discard, m_held, m_mis;
  logic [31:0] m_held_instr;
  logic        m_vld;
  logic [63:0] m_ipc;
  logic [31:0] m_instr;
  logic [63:0] mem_addr;
  int          mem_delay;

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .ADDR_W  (64),
    .INSTR_W (32),
    .RESET_PC(RST_PC),
    .PC_STEP (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .ifid_valid   (ifid_valid),
    .ifid_pc      (ifid_pc),
    .ifid_instr   (ifid_instr),
    .misalign_err (misalign_err)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_pc         = RST_PC;
    m_busy       = 1'b0;
    m_discard    = 1'b0;
    m_held       = 1'b0;
    m_held_instr = '0;
    m_mis        = 1'b0;
    m_vld        = 1'b0;
    m_ipc        = '0;
    m_instr      = '0;
    mem_delay    = 0;
    mem_addr     = '0;
  endtask

  task automatic checkAll();
    checkOutput("imem_req",     64'(imem_req),     64'(!reset && !m_busy && !m_held));
    checkOutput("imem_addr",    imem_addr,         m_pc);
    checkOutput("ifid_valid",   64'(ifid_valid),   64'(m_vld));
    checkOutput("ifid_pc",      ifid_pc,           m_ipc);
    checkOutput("ifid_instr",   64'(ifid_instr),   64'(m_instr));
    checkOutput("misalign_err", 64'(misalign_err), 64'(m_mis));
  endtask

  // Drives one cycle of inputs (at the falling edge) and advances the model.
  task automatic applyStimulus();
    logic        rst, st, br, rdy, rv, accepted, delivered;
    logic [63:0] tgt, old_pc, dpc;
    logic [31:0] rd, dinstr;

    rst = ($urandom_range(0, 149) == 0);
    st  = ($urandom_range(0, 2) == 0);
    br  = ($urandom_range(0, 11) == 0);
    case ($urandom_range(0, 3))
      0:       tgt = {$urandom, $urandom} & ~64'h3;
      1:       tgt = {$urandom, $urandom};
      2:       tgt = 64'hFFFF_FFFF_FFFF_FFFC;
      default: tgt = 64'h2000 + 64'($urandom_range(0, 15));
    endcase
    rdy = ($urandom_range(0, 2) != 0);
    rv  = m_busy && (mem_delay == 0);
    rd  = rv ? mem_word(mem_addr) : $urandom;
    if (rst) begin
      rdy = 1'b0;
      rv  = 1'b0;
    end

    reset         = rst;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    imem_ready    = rdy;
    imem_rvalid   = rv;
    imem_rdata    = rd;

    if (rst) begin
      #1;
      checkOutput("req_in_reset", 64'(imem_req), 64'd0);
    end

    old_pc    = m_pc;
    accepted  = !m_busy && !m_held && rdy;
    delivered = 1'b0;
    dpc       = '0;
    dinstr    = '0;

    if (rst) begin
      modelReset();
    end else if (br) begin
      m_pc      = {tgt[63:2], 2'b00};
      m_vld     = 1'b0;
      m_mis     = (tgt[1:0] != 2'b00);
      m_held    = 1'b0;
      m_busy    = accepted || (m_busy && !rv);
      m_discard = m_busy;
    end else begin
      m_mis = 1'b0;
      if (rv) begin
        if (!m_discard && !st) begin
          delivered = 1'b1;
          dpc       = old_pc;
          dinstr    = rd;
        end else if (!m_discard) begin
          m_held       = 1'b1;
          m_held_instr = rd;
        end
        m_busy    = 1'b0;
        m_discard = 1'b0;
      end else if (m_held && !st) begin
        delivered = 1'b1;
        dpc       = old_pc;
        dinstr    = m_held_instr;
        m_held    = 1'b0;
      end
      if (accepted) m_busy = 1'b1;
      if (delivered) begin
        m_vld   = 1'b1;
        m_ipc   = dpc;
        m_instr = dinstr;
        m_pc    = old_pc + 64'd4;
      end else if (!st) begin
        m_vld = 1'b0;
      end
    end

    if (!rst) begin
      if (accepted) begin
        mem_addr  = old_pc;
        mem_delay = $urandom_range(0, 2);
      end else if (m_busy) begin
        mem_delay--;
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    imem_ready    = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = '0;
    modelReset();
    @(posedge clk);
    @(negedge clk);
    checkAll();
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      applyStimulus();
      @(negedge clk);
      checkAll();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
